// File: rtl/rv_pkg.sv
// Shared core package: ALU and M-extension opcode types plus the divider's
// operation encoding and iteration count.
package rv_pkg;

  localparam int CORE_XLEN = 32;
  localparam int DIV_ITERS = CORE_XLEN;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } mext_op_e;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for the EXE stage: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
//
// state  | meaning
// S_IDLE | waiting for start; special cases finish straight from here
// S_CALC | one shift-subtract step per cycle, DIV_ITERS cycles
// S_DONE | result valid, done pulses for this one cycle
module div_unit
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q;
  div_op_e         op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, result_q;

  div_op_e         op_in;
  logic            accept, in_signed, in_rem;
  logic            a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign op_in     = div_op_e'(op);
  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign in_signed = (op_in == DIV_OP_DIV) || (op_in == DIV_OP_REM);
  assign in_rem    = (op_in == DIV_OP_REM) || (op_in == DIV_OP_REMU);
  assign a_neg     = in_signed && opa[XLEN-1];
  assign b_neg     = in_signed && opb[XLEN-1];
  assign mag_a     = a_neg ? -opa : opa;
  assign mag_b     = b_neg ? -opb : opb;
  assign div_zero  = (opb == '0);
  assign overflow  = in_signed && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
  assign special   = div_zero || overflow;

  // overflow: dividend is the most negative value, so it doubles as the quotient
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = in_rem ? opa : '1;
    else          special_res = in_rem ? '0 : opa;
  end

  // Dividend magnitude is shifted out of quo_q as quotient bits shift in.
  logic [XLEN:0]   rem_shift, diff;
  logic            fit;
  logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin, fin_res;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    fit       = ~diff[XLEN];
    rem_n     = fit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_n     = {quo_q[XLEN-2:0], fit};
    q_fin     = (sign_a_q ^ sign_b_q) ? -quo_n : quo_n;
    r_fin     = sign_a_q ? -rem_n : rem_n;
    fin_res   = ((op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU)) ? r_fin : q_fin;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)             state_d = S_IDLE;
        else if (cnt_q == 6'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = accept || (state_q == S_CALC);
    done   = (state_q == S_DONE);
    result = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= DIV_OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      sign_a_q <= a_neg;
      sign_b_q <= b_neg;
      quo_q    <= mag_a;
      rem_q    <= '0;
      dvs_q    <= mag_b;
      cnt_q    <= 6'(DIV_ITERS);
      if (special) result_q <= special_res;
    end else if (state_q == S_CALC && !flush) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) result_q <= fin_res;
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 clk  input  1  Clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 start  input  1  EXE-stage request; qualifies op, opa, opb in the same cycle.
REQ-005 op  input  2  Operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 opa  input  XLEN  Dividend (rs1).
REQ-007 opb  input  XLEN  Divisor (rs2).
REQ-008 flush  input  1  Kill request, driven from the hazard unit's FlushE.
REQ-009 busy  output  1  Stall request to the hazard unit; the hazard unit ORs it into StallF/StallD and holds EXE.
REQ-010 done  output  1  One-cycle pulse; result is valid in this cycle.
REQ-011 result  output  XLEN  Quotient or remainder, selected by the latched op.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 and flush=0, the unit SHALL latch op, the operand signs, and the operand magnitudes, then go to CALC, or to DONE for the special cases in REQ-019 and REQ-020.
REQ-014 busy SHALL equal (IDLE & start & ~flush) | CALC, so the pipeline stalls in the request cycle itself.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle for exactly XLEN cycles, using a 6-bit down-counter, then go to DONE.
REQ-016 Normal latency: start in cycle 0, CALC in cycles 1..32, DONE in cycle 33 with done=1 and busy=0. From DONE the FSM SHALL return to IDLE.
REQ-017 Signed ops (DIV, REM) SHALL divide magnitudes. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
REQ-018 Unsigned ops (DIVU, REMU) SHALL use the operands unmodified.
REQ-019 Divide by zero (opb=0) SHALL go directly to DONE, with done in cycle 1. Quotient = all ones. Remainder = opa.
REQ-020 Signed overflow (opa=0x8000_0000, opb=0xFFFF_FFFF, op DIV or REM) SHALL go directly to DONE, with done in cycle 1. Quotient = 0x8000_0000. Remainder = 0.
REQ-021 start SHALL be ignored in CALC and DONE.
REQ-022 A back-to-back start is accepted in the IDLE cycle that follows DONE.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge. done SHALL NOT be asserted for the killed operation.
REQ-024 flush and start in the same IDLE cycle: start SHALL be ignored and busy=0.
REQ-025 flush in the DONE cycle: done remains 1 in that cycle. The pipeline decides whether to use the result.
REQ-026 result SHALL hold its last value outside DONE.

Reset
REQ-027 rst=1 SHALL force, on the next edge, state=IDLE, counter=0, and all datapath registers=0, overriding start and flush.
REQ-028 After reset: busy=0, done=0, result=0.
REQ-029 Reset during CALC SHALL abandon the operation with no done pulse.

Structure
REQ-030 The op encoding (div_op_e) and the DIV_ITERS=XLEN constant SHALL live in the shared core package rv_pkg, alongside the existing ALU and M-extension opcode types.
REQ-031 The FSM state type SHALL be local to div_unit.
REQ-032 The block SHALL be a single module, div_unit, with no sub-module; the shift-subtract datapath is small enough to keep inline.

Verification
REQ-033 DIVU, opa=100, opb=7 -> busy high in cycles 0..32; done in cycle 33; result=14. Repeat with REMU -> result=2.
REQ-034 DIV, opa=-7 (0xFFFF_FFF9), opb=2 -> result=0xFFFF_FFFD (-3). REM with the same operands -> result=0xFFFF_FFFF (-1).
REQ-035 DIV, opb=0, opa=0x1234 -> done in cycle 1, result=0xFFFF_FFFF. REM, opb=0 -> result=0x1234.
REQ-036 DIV, opa=0x8000_0000, opb=0xFFFF_FFFF -> done in cycle 1, result=0x8000_0000. REM with the same operands -> result=0.
REQ-037 Start DIVU 50/5, assert flush in cycle 10 -> IDLE in cycle 11, busy=0, no done pulse. A new DIVU 9/3 in cycle 12 -> done in cycle 45, result=3.
REQ-038 Start DIV, assert rst in cycle 5 -> busy=0 and done=0 from cycle 6. start and flush asserted together in IDLE -> busy=0 and no state change.
